ram_rd_stream: RTL and testbench
================================

RAM_RD_STREAM -- requirements
Module: ram_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, meaning the RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning the RAM address width.
REQ-003 SHALL have parameter BURST_WIDTH, default 8, meaning the burst length field width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port wr_req_mon, input, 1 bit: copy of the upstream write strobe into the RAM, used for occupancy tracking.
REQ-007 SHALL have port start, input, 1 bit: single-cycle burst request.
REQ-008 SHALL have port burst_len, input, BURST_WIDTH bits: words to read, sampled with start.
REQ-009 SHALL have port rd_req, output, 1 bit: read strobe to the sequential-address RAM.
REQ-010 SHALL have port rd_data, input, DATA_WIDTH bits: RAM read data, valid exactly 1 cycle after rd_req.
REQ-011 SHALL have port m_valid, output, 1 bit, and port m_data, output, DATA_WIDTH bits: downstream stream.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accept; a transfer occurs when m_valid && m_ready.
REQ-013 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.
REQ-015 SHALL have port level, output, ADDR_WIDTH+1 bits: unread words in the RAM.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-017 SHALL, in IDLE on start with burst_len>0, load remaining=burst_len and enter RUN.
REQ-018 SHALL, in IDLE on start with burst_len==0, pulse done on the next cycle and stay in IDLE.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL assert rd_req in RUN only when all hold: remaining>0, level>0, and (words in flight + skid entries) < 2.
REQ-021 SHALL decrement remaining on each rd_req and enter DRAIN when it reaches 0.
REQ-022 SHALL capture rd_data into a 2-entry skid buffer in the cycle after each rd_req; the buffer never overflows and m_data/m_valid come from its head.
REQ-023 SHALL, in DRAIN, transition to IDLE with a done pulse once nothing is in flight and the skid buffer is empty after the final handshake.
REQ-024 SHALL give a minimum latency of 2 cycles from start to the first m_valid.
REQ-025 SHALL sustain 1 word/cycle while m_ready=1 and level>0.
REQ-026 SHALL update level: +1 on wr_req_mon, -1 on rd_req, unchanged when both occur in the same cycle.
REQ-027 SHALL saturate level at 2^ADDR_WIDTH on increment and never let it go below 0.
REQ-028 SHALL keep m_data stable while m_valid=1 and m_ready=0.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: FSM=IDLE, remaining=0, level=0, skid buffer empty, rd_req=0, m_valid=0, m_data=0, busy=0, done=0.
REQ-030 SHALL, on reset asserted mid-burst, abort the burst with no done pulse, so the first post-reset start begins a fresh burst.

Configuration
REQ-031 SHALL, with macro RD_STREAM_OVF_EN defined, add output ovf (1 bit), a sticky flag set when wr_req_mon arrives at saturated level and cleared only by reset.
REQ-032 SHALL, without RD_STREAM_OVF_EN, omit the ovf port and saturate level silently.

Structure
REQ-033 SHALL take the FSM state enum and the skid depth constant (2) from shared package ram_stream_pkg.
REQ-034 SHALL implement the skid buffer as sub-module skid_fifo2 (2-entry, valid/ready, registered outputs).

Verification
REQ-035 SHALL cover: 5 writes, then start with burst_len=4 and m_ready=1 -> 4 words in write order, done 1 cycle after the last handshake, level=1.
REQ-036 SHALL cover: level=0, start with burst_len=3, then writes spaced every 3 cycles -> rd_req only after each write, 3 words out, then done.
REQ-037 SHALL cover: burst of 6 with m_ready toggling 1,0,0,1 -> no loss or duplication, m_data held while stalled, at most 2 reads outstanding.
REQ-038 SHALL cover: wr_req_mon and rd_req in the same cycle with level=2 -> level stays 2.
REQ-039 SHALL cover: start with burst_len=0 -> done pulse next cycle, busy stays 0, no rd_req.
REQ-040 SHALL cover: reset pulled low on the 3rd word of an 8-word burst -> all outputs 0 immediately, no done pulse, and a new burst of 2 completes correctly.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM read-stream block: FSM state encoding
// and the depth of the output skid buffer.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid buffer. Outputs come straight from registers: m_data_o is
// the head register and m_valid_o is derived from the occupancy register.
// Handshake: a word moves on a port in any cycle where valid && ready are
// both high; valid never depends combinationally on ready.
module skid_fifo2
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign s_ready_o = (cnt_q != 2'(SKID_DEPTH));
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = head_q;
  assign count_o   = cnt_q;
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  // Next-state for the head/tail registers and occupancy.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = s_data_i;
        else               tail_d = s_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Keep the head unchanged when emptying so the data bus stays quiet.
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = s_data_i;
        end else begin
          head_d = tail_q;
          tail_d = s_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage registers, cleared to an empty buffer with zero data.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_rd_stream.sv
// Burst reader for a sequential-address RAM. Tracks how many unread words
// the RAM holds, issues reads only when a word exists and the skid buffer
// can absorb the returning data, and streams words out in RAM order.
// Optional build macro: RD_STREAM_OVF_EN adds a sticky overflow flag (ovf).
module ram_rd_stream
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int ADDR_WIDTH  = 12,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_req_mon,
  input  logic                   start,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   rd_req,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    level,
`ifdef RD_STREAM_OVF_EN
  output logic                   ovf,
`endif
  output logic [1:0]             dbg_state
);

  localparam logic [ADDR_WIDTH:0]    LEVEL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [BURST_WIDTH-1:0] REM_ONE   = BURST_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH:0]    level_q, level_d;
  logic                   inflight_q;
  logic                   done_q, done_d;
  logic [1:0]             skid_cnt;
  logic [1:0]             skid_after;
  logic [1:0]             in_use;
  logic                   skid_ready;
  logic                   pop;
  logic                   can_issue;

  assign pop        = m_valid && m_ready;
  // Occupancy counted after this cycle's pop so a streaming sink keeps one
  // read issued every cycle.
  assign skid_after = skid_cnt - {1'b0, pop};
  assign in_use     = {1'b0, inflight_q} + skid_after;
  assign can_issue  = (in_use < 2'(SKID_DEPTH)) && (skid_ready || pop);

  assign rd_req    = (state_q == ST_RUN) && (remaining_q != '0) &&
                     (level_q != '0) && can_issue;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign level     = level_q;
  assign dbg_state = state_q;

  // FSM next-state, burst countdown and completion pulse.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            state_d     = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd_req) begin
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && pop))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM occupancy: simultaneous write and read cancel, increments saturate.
  always_comb begin
    level_d = level_q;
    if (wr_req_mon && !rd_req) begin
      if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
    end else if (rd_req && !wr_req_mon) begin
      level_d = level_q - 1'b1;
    end
  end

  // Control and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      level_q     <= level_d;
      inflight_q  <= rd_req;
      done_q      <= done_d;
    end
  end

`ifdef RD_STREAM_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;

  // Sticky flag: a write landed while the RAM was already full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else if (wr_req_mon && !rd_req && (level_q == LEVEL_MAX)) ovf_q <= 1'b1;
  end
`endif

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_ni   (reset),
    .s_valid_i(inflight_q),
    .s_ready_o(skid_ready),
    .s_data_i (rd_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o (m_data),
    .count_o  (skid_cnt)
  );

endmodule

// File: tb/tb_ram_rd_stream.sv
// Bench for ram_rd_stream: a RAM model answers rd_req one cycle later, a
// negedge monitor compares the stream against the write-order queue and an
// arithmetic occupancy model, and scenario tasks check each behaviour.
module tb_ram_rd_stream;
  localparam int DW   = 10;
  localparam int AW   = 4;
  localparam int BW   = 8;
  localparam int LMAX = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_req_mon = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          rd_req;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   level;
  logic [1:0]    dbg_state;

  ram_rd_stream #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset), .wr_req_mon(wr_req_mon), .start(start),
    .burst_len(burst_len), .rd_req(rd_req), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
    .done(done), .level(level), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (!reset) begin
      rd_ptr = wr_ptr;
    end else begin
      if (wr_req_mon) begin mem[wr_ptr % 1024] = wr_data; wr_ptr++; end
      if (rd_req) begin rd_data <= mem[rd_ptr % 1024]; rd_ptr++; end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int data_err, level_err, stall_err, rd_empty_err, max_occ;
  int rd_cnt, hs_cnt, done_cnt, level_m;
  int first_valid_cyc, start_cyc, last_hs_cyc, done_cyc;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      level_m = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (int'(level) != level_m) level_err++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_err++;
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (rd_req && level_m == 0) rd_empty_err++;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) data_err++;
        else if (m_data !== exp_q.pop_front()) data_err++;
        got_q.push_back(m_data);
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (rd_req) rd_cnt++;
      if (rd_cnt - hs_cnt > max_occ) max_occ = rd_cnt - hs_cnt;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (start && !busy) start_cyc = cyc + 1;
      if (wr_req_mon) exp_q.push_back(wr_data);
      if (wr_req_mon && !rd_req) begin
        if (level_m < LMAX) level_m++;
      end else if (rd_req && !wr_req_mon) begin
        level_m--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    data_err = 0; level_err = 0; stall_err = 0; rd_empty_err = 0;
    max_occ = 0; rd_cnt = 0; hs_cnt = 0; done_cnt = 0;
    first_valid_cyc = -1; start_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    got_q.delete();
  endtask

  task automatic apply_reset;
    start = 1'b0; wr_req_mon = 1'b0; m_ready = 1'b1;
    reset = 1'b0;
    tick; tick;
    reset = 1'b1;
    clear_mon();
  endtask

  task automatic wr_word;
    wr_req_mon = 1'b1;
    wr_data = DW'($urandom_range(0, 1023));
    tick;
    wr_req_mon = 1'b0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    burst_len = BW'(len);
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin ok = 1'b1; break; end
      tick;
    end
    if (done_cnt != d0) ok = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b0;
    tick; tick; tick;
    checks++;
    if ({rd_req, m_valid, busy, done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {rd_req, m_valid, busy, done});
    end
    checks++;
    if (m_data !== '0 || level !== '0) begin
      errors++; $display("FAIL reset_data: m_data=%0d level=%0d want 0 0", m_data, level);
    end
    reset = 1'b1;
    clear_mon();
  endtask

  task automatic test_burst4;
    bit ok;
    apply_reset();
    repeat (5) wr_word();
    checks++;
    if (level !== 5) begin errors++; $display("FAIL b4_prefill_level: got %0d want 5", level); end
    do_start(4);
    wait_done(0, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b4_done_timeout: no done seen, want one"); end
    checks++;
    if (got_q.size() != 4 || data_err != 0) begin
      errors++; $display("FAIL b4_words: got %0d words %0d bad, want 4 words 0 bad", got_q.size(), data_err);
    end
    checks++;
    if (first_valid_cyc - start_cyc != 2) begin
      errors++; $display("FAIL b4_latency: got %0d want 2", first_valid_cyc - start_cyc);
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      errors++; $display("FAIL b4_done_timing: done at %0d last handshake %0d, want +1", done_cyc, last_hs_cyc);
    end
    tick;
    checks++;
    if (level !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL b4_end: level=%0d busy=%b want 1 0", level, busy);
    end
  endtask

  task automatic test_sparse;
    bit ok;
    apply_reset();
    do_start(3);
    repeat (4) tick;
    checks++;
    if (rd_cnt != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL sparse_wait: rd_req count %0d busy %b, want 0 1", rd_cnt, busy);
    end
    for (int i = 0; i < 3; i++) begin
      wr_word();
      tick; tick;
    end
    wait_done(0, 30, ok);
    checks++;
    if (!ok || got_q.size() != 3 || data_err != 0) begin
      errors++; $display("FAIL sparse_words: done=%0d words=%0d bad=%0d want 1 3 0", ok, got_q.size(), data_err);
    end
    checks++;
    if (rd_empty_err != 0 || rd_cnt != 3 || level_err != 0) begin
      errors++; $display("FAIL sparse_reads: empty_reads=%0d reads=%0d level_errs=%0d want 0 3 0",
                         rd_empty_err, rd_cnt, level_err);
    end
  endtask

  task automatic test_stall;
    logic [3:0] pat = 4'b1001;
    apply_reset();
    repeat (8) wr_word();
    do_start(6);
    for (int i = 0; i < 80; i++) begin
      m_ready = pat[3 - (i % 4)];
      start = (i == 3);
      burst_len = BW'(5);
      tick;
      start = 1'b0;
      if (done_cnt != 0) break;
    end
    m_ready = 1'b1;
    repeat (4) tick;
    checks++;
    if (done_cnt != 1 || got_q.size() != 6 || data_err != 0) begin
      errors++; $display("FAIL stall_words: dones=%0d words=%0d bad=%0d want 1 6 0", done_cnt, got_q.size(), data_err);
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_err); end
    checks++;
    if (max_occ > 2) begin errors++; $display("FAIL stall_outstanding: got %0d want <=2", max_occ); end
    checks++;
    if (level !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_end: level=%0d busy=%b want 2 0", level, busy);
    end
  endtask

  task automatic test_same_cycle;
    bit ok;
    apply_reset();
    repeat (2) wr_word();
    do_start(1);
    wr_req_mon = 1'b1;
    wr_data = DW'($urandom_range(0, 1023));
    checks++;
    if (rd_req !== 1'b1 || level !== 2) begin
      errors++; $display("FAIL same_pre: rd_req=%b level=%0d want 1 2", rd_req, level);
    end
    tick;
    wr_req_mon = 1'b0;
    checks++;
    if (level !== 2) begin errors++; $display("FAIL same_level: got %0d want 2", level); end
    wait_done(0, 20, ok);
    checks++;
    if (!ok || got_q.size() != 1 || data_err != 0) begin
      errors++; $display("FAIL same_word: done=%0d words=%0d bad=%0d want 1 1 0", ok, got_q.size(), data_err);
    end
  endtask

  task automatic test_zero_len;
    int r0 = rd_cnt;
    do_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_pulse: done=%b busy=%b want 1 0", done, busy);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_cnt != r0) begin
      errors++; $display("FAIL zero_after: done=%b busy=%b reads=%0d want 0 0 %0d", done, busy, rd_cnt, r0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    apply_reset();
    repeat (8) wr_word();
    do_start(8);
    for (int i = 0; i < 40; i++) begin
      if (hs_cnt >= 2 && m_valid) break;
      tick;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({rd_req, m_valid, busy, done} !== 4'b0 || m_data !== '0 || level !== '0) begin
      errors++; $display("FAIL midrst_outputs: ctrl=%b m_data=%0d level=%0d want 0", {rd_req, m_valid, busy, done},
                         m_data, level);
    end
    tick; tick;
    reset = 1'b1;
    clear_mon();
    repeat (3) tick;
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    repeat (2) wr_word();
    do_start(2);
    wait_done(0, 30, ok);
    tick;
    checks++;
    if (!ok || got_q.size() != 2 || data_err != 0 || level !== 0) begin
      errors++; $display("FAIL midrst_new_burst: done=%0d words=%0d bad=%0d level=%0d want 1 2 0 0",
                         ok, got_q.size(), data_err, level);
    end
  endtask

  task automatic test_saturate;
    apply_reset();
    repeat (LMAX + 3) wr_word();
    checks++;
    if (int'(level) != LMAX || level_err != 0) begin
      errors++; $display("FAIL sat_level: got %0d (model errs %0d) want %0d", level, level_err, LMAX);
    end
  endtask

  task automatic test_random;
    bit ok;
    int len, h0, d0;
    apply_reset();
    for (int it = 0; it < 6; it++) begin
      for (int n = $urandom_range(0, 4); n > 0; n--) wr_word();
      len = $urandom_range(1, 8);
      h0 = hs_cnt;
      d0 = done_cnt;
      do_start(len);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        wr_req_mon = (level_m < 12) && ($urandom_range(0, 1) == 1);
        wr_data = DW'($urandom_range(0, 1023));
        m_ready = ($urandom_range(0, 3) != 0);
        tick;
        if (done_cnt != d0) begin ok = 1'b1; break; end
      end
      wr_req_mon = 1'b0;
      m_ready = 1'b1;
      tick;
      checks++;
      if (!ok || hs_cnt - h0 != len) begin
        errors++; $display("FAIL rand_burst%0d: done=%0d words=%0d want 1 %0d", it, ok, hs_cnt - h0, len);
      end
    end
    checks++;
    if (data_err != 0 || level_err != 0 || stall_err != 0 || max_occ > 2) begin
      errors++; $display("FAIL rand_model: data=%0d level=%0d hold=%0d occ=%0d want 0 0 0 <=2",
                         data_err, level_err, stall_err, max_occ);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_mon();
    test_reset();
    test_burst4();
    test_sparse();
    test_stall();
    test_same_cycle();
    test_zero_len();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
